// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared control-path types for the pipelined RV32IM core:
// opcodes, ALU/MD encodings, per-stage control words.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLT    = 5'd5;
    localparam logic [4:0] ALU_SLTU   = 5'd6;
    localparam logic [4:0] ALU_SLL    = 5'd7;
    localparam logic [4:0] ALU_SRL    = 5'd8;
    localparam logic [4:0] ALU_SRA    = 5'd9;
    localparam logic [4:0] ALU_LUI    = 5'd10;
    // M-ext codes are {2'b10, funct3}
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [4:0] alu_ctrl;
        logic       alu_src;
        logic       alu_src_a;
        logic       md_op;
        logic       md_div;
    } ctrl_word_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } m_word_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } w_word_t;

    localparam ctrl_word_t BUBBLE   = '0;
    localparam m_word_t    M_BUBBLE = '0;
    localparam w_word_t    W_BUBBLE = '0;

    function automatic logic [4:0] alu_base(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [4:0] v;
        v = ALU_ADD;
        case (f3)
            3'b000:  v = alt ? ALU_SUB : ALU_ADD;
            3'b001:  v = ALU_SLL;
            3'b010:  v = ALU_SLT;
            3'b011:  v = ALU_SLTU;
            3'b100:  v = ALU_XOR;
            3'b101:  v = alt ? ALU_SRA : ALU_SRL;
            3'b110:  v = ALU_OR;
            default: v = ALU_AND;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Decode inputs, hazard controls and per-stage control
// outputs of the pipelined control unit.
interface pipe_ctrl_unit_if #(
    parameter int ALUCTRL_W = 5
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7_5;
    logic                 funct7_0;
    logic                 StallD;
    logic                 FlushE;
    logic [2:0]           ImmSrcD;
    logic [ALUCTRL_W-1:0] ALUControlE;
    logic                 ALUSrcE;
    logic                 ALUSrcAE;
    logic                 BranchE;
    logic                 JumpE;
    logic                 RegWriteE;
    logic                 MemWriteE;
    logic                 MemWriteM;
    logic [1:0]           ResultSrcM;
    logic                 RegWriteM;
    logic [1:0]           ResultSrcW;
    logic                 RegWriteW;
    logic                 MdStart;
    logic                 StallMd;

    modport master (
        output op, funct3, funct7_5, funct7_0, StallD, FlushE,
        input  ImmSrcD, ALUControlE, ALUSrcE, ALUSrcAE,
        input  BranchE, JumpE, RegWriteE, MemWriteE,
        input  MemWriteM, ResultSrcM, RegWriteM,
        input  ResultSrcW, RegWriteW, MdStart, StallMd
    );

    modport slave (
        input  op, funct3, funct7_5, funct7_0, StallD, FlushE,
        output ImmSrcD, ALUControlE, ALUSrcE, ALUSrcAE,
        output BranchE, JumpE, RegWriteE, MemWriteE,
        output MemWriteM, ResultSrcM, RegWriteM,
        output ResultSrcW, RegWriteW, MdStart, StallMd
    );
endinterface

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational Decode-stage control: opcode/funct to
// control word and immediate select.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_funct7_0,
    output ctrl_word_t o_ctrl,
    output logic [2:0] o_imm_src
);
    logic w_sra_i;

    assign w_sra_i = (i_funct3 == 3'b101) & i_funct7_5;

    // One arm per instruction class; unknown opcodes stay a bubble
    always_comb begin
        o_ctrl    = BUBBLE;
        o_imm_src = IMM_I;
        unique case (1'b1)
            (i_op == OP_R): begin
                o_ctrl.reg_write = 1'b1;
                if (i_funct7_0) begin
                    o_ctrl.alu_ctrl = {2'b10, i_funct3};
                    o_ctrl.md_op    = 1'b1;
                    o_ctrl.md_div   = i_funct3[2];
                end else begin
                    o_ctrl.alu_ctrl = alu_base(i_funct3, i_funct7_5);
                end
            end
            (i_op == OP_IMM): begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_ctrl  = alu_base(i_funct3, w_sra_i);
            end
            (i_op == OP_LOAD): begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.result_src = RES_MEM;
                o_ctrl.alu_src    = 1'b1;
            end
            (i_op == OP_STORE): begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_imm_src        = IMM_S;
            end
            (i_op == OP_BRANCH): begin
                o_ctrl.branch   = 1'b1;
                o_ctrl.alu_ctrl = ALU_SUB;
                o_imm_src       = IMM_B;
            end
            (i_op == OP_JAL): begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.result_src = RES_PC4;
                o_ctrl.jump       = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.alu_src_a  = 1'b1;
                o_imm_src         = IMM_J;
            end
            (i_op == OP_JALR): begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.result_src = RES_PC4;
                o_ctrl.jump       = 1'b1;
                o_ctrl.alu_src    = 1'b1;
            end
            (i_op == OP_LUI): begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_ctrl  = ALU_LUI;
                o_imm_src        = IMM_U;
            end
            (i_op == OP_AUIPC): begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_src_a = 1'b1;
                o_imm_src        = IMM_U;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32IM control: D/E, E/M, M/W control registers
// and the multi-cycle MUL/DIV sequencer in Execute.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 8,
    parameter int ALUCTRL_W  = 5
) (
    input logic             clk,
    input logic             rst,
    pipe_ctrl_unit_if.slave bus
);
    localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ?
                           MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    ctrl_word_t       w_dec;
    logic [2:0]       w_imm;
    ctrl_word_t       r_e;
    m_word_t          r_m;
    w_word_t          r_w;
    md_state_t        r_state;
    md_state_t        w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_load;
    logic             w_multi;
    logic             w_stall;
    logic             w_start;

    ctrl_decode u_dec (
        .i_op      (bus.op),
        .i_funct3  (bus.funct3),
        .i_funct7_5(bus.funct7_5),
        .i_funct7_0(bus.funct7_0),
        .o_ctrl    (w_dec),
        .o_imm_src (w_imm)
    );

    assign w_multi = r_e.md_div ? (DIV_CYCLES > 1) : (MUL_CYCLES > 1);
    assign w_load  = r_e.md_div ? CNT_W'(DIV_CYCLES - 2)
                                : CNT_W'(MUL_CYCLES - 2);

    // MD sequencer next state, countdown and front-end freeze
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_stall    = 1'b0;
        w_start    = 1'b0;
        unique case (r_state)
            MD_IDLE: begin
                if (r_e.md_op) begin
                    w_start = 1'b1;
                    if (w_multi) begin
                        w_stall    = 1'b1;
                        w_state_nx = MD_BUSY;
                        w_cnt_nx   = w_load;
                    end
                end
            end
            MD_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nx = MD_IDLE;
                end else begin
                    w_stall  = 1'b1;
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nx = MD_IDLE;
        endcase
    end

    // MD sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // D->E: an in-flight M op holds E ahead of flush/stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e <= BUBBLE;
        end else if (w_stall) begin
            r_e <= r_e;
        end else if (bus.FlushE || bus.StallD) begin
            r_e <= BUBBLE;
        end else begin
            r_e <= w_dec;
        end
    end

    // E->M and M->W: bubble into M while E is occupied
    always_ff @(posedge clk) begin
        if (rst || w_stall) begin
            r_m <= M_BUBBLE;
        end else begin
            r_m <= '{r_e.reg_write, r_e.result_src, r_e.mem_write};
        end
        if (rst) begin
            r_w <= W_BUBBLE;
        end else begin
            r_w <= '{r_m.reg_write, r_m.result_src};
        end
    end

    assign bus.ImmSrcD     = w_imm;
    assign bus.ALUControlE = ALUCTRL_W'(r_e.alu_ctrl);
    assign bus.ALUSrcE     = r_e.alu_src;
    assign bus.ALUSrcAE    = r_e.alu_src_a;
    assign bus.BranchE     = r_e.branch;
    assign bus.JumpE       = r_e.jump;
    assign bus.RegWriteE   = r_e.reg_write;
    assign bus.MemWriteE   = r_e.mem_write;
    assign bus.MemWriteM   = r_m.mem_write;
    assign bus.ResultSrcM  = r_m.result_src;
    assign bus.RegWriteM   = r_m.reg_write;
    assign bus.ResultSrcW  = r_w.result_src;
    assign bus.RegWriteW   = r_w.reg_write;
    assign bus.MdStart     = w_start;
    assign bus.StallMd     = w_stall;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: expectations are queued
// with a due cycle when stimulus is driven, checked at negedge.
module tb_pipe_ctrl_unit;
    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_LD   = 7'b0000011;
    localparam logic [6:0] T_ST   = 7'b0100011;
    localparam logic [6:0] T_BR   = 7'b1100011;
    localparam logic [6:0] T_JAL  = 7'b1101111;
    localparam logic [6:0] T_AUI  = 7'b0010111;
    localparam logic [6:0] T_NOP  = 7'b0000000;
    localparam logic [6:0] T_BAD  = 7'b1111111;

    typedef enum int {
        S_RWE, S_MWE, S_ALUE, S_BRE, S_JE, S_SRCAE,
        S_RWM, S_MWM, S_RWW, S_RSW, S_IMMD, S_STALL, S_START
    } sig_e;

    typedef struct {
        int    due;
        sig_e  sig;
        int    exp;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    pipe_ctrl_unit_if #(.ALUCTRL_W(5)) bus();

    pipe_ctrl_unit #(
        .MUL_CYCLES(1),
        .DIV_CYCLES(8),
        .ALUCTRL_W (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] peek(input sig_e s);
        case (s)
            S_RWE:   return 32'(bus.RegWriteE);
            S_MWE:   return 32'(bus.MemWriteE);
            S_ALUE:  return 32'(bus.ALUControlE);
            S_BRE:   return 32'(bus.BranchE);
            S_JE:    return 32'(bus.JumpE);
            S_SRCAE: return 32'(bus.ALUSrcAE);
            S_RWM:   return 32'(bus.RegWriteM);
            S_MWM:   return 32'(bus.MemWriteM);
            S_RWW:   return 32'(bus.RegWriteW);
            S_RSW:   return 32'(bus.ResultSrcW);
            S_IMMD:  return 32'(bus.ImmSrcD);
            S_STALL: return 32'(bus.StallMd);
            default: return 32'(bus.MdStart);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk($sformatf("%s@%0d", sb[i].tag, cyc),
                    peek(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic exp_at(input int dly, input sig_e s, input int v,
                          input string tag);
        exp_t e;
        e.due = cyc + dly;
        e.sig = s;
        e.exp = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic set_d(input logic [6:0] o, input logic [2:0] f3,
                         input logic f5, input logic f0);
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7_5 = f5;
        bus.funct7_0 = f0;
    endtask

    task automatic hz(input logic sd, input logic fe);
        bus.StallD = sd;
        bus.FlushE = fe;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        hz(1'b0, 1'b0);
        set_d(T_R, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        // reset state, then ADD latency 1/2/3
        foreach (sb[i]) sb.delete(i);
        exp_at(0, S_RWE, 0, "rst_rwe");
        exp_at(0, S_MWE, 0, "rst_mwe");
        exp_at(0, S_ALUE, 0, "rst_alu");
        exp_at(0, S_RWM, 0, "rst_rwm");
        exp_at(0, S_MWM, 0, "rst_mwm");
        exp_at(0, S_RWW, 0, "rst_rww");
        exp_at(0, S_STALL, 0, "rst_stall");
        exp_at(0, S_START, 0, "rst_start");
        rst = 1'b0;
        exp_at(1, S_RWE, 1, "add_rwe");
        exp_at(1, S_ALUE, 0, "add_alu");
        exp_at(1, S_RWM, 0, "add_rwm_early");
        exp_at(2, S_RWM, 1, "add_rwm");
        exp_at(2, S_RWW, 0, "add_rww_early");
        exp_at(3, S_RWW, 1, "add_rww");
        tick();
        set_d(T_JAL, 3'b000, 1'b0, 1'b0);
        exp_at(0, S_IMMD, 3, "jal_imm");
        exp_at(1, S_JE, 1, "jal_je");
        exp_at(1, S_SRCAE, 1, "jal_srca");
        exp_at(3, S_RSW, 2, "jal_rsw");
        exp_at(3, S_RWW, 1, "jal_rww");
        tick();
        set_d(T_AUI, 3'b000, 1'b0, 1'b0);
        exp_at(0, S_IMMD, 4, "aui_imm");
        exp_at(1, S_SRCAE, 1, "aui_srca");
        exp_at(1, S_JE, 0, "aui_je");
        exp_at(1, S_RWE, 1, "aui_rwe");
        tick();
        set_d(T_BAD, 3'b000, 1'b0, 1'b0);
        exp_at(1, S_RWE, 0, "bad_rwe");
        exp_at(1, S_MWE, 0, "bad_mwe");
        exp_at(1, S_JE, 0, "bad_je");
        exp_at(1, S_BRE, 0, "bad_bre");
        tick();
        set_d(T_NOP, 3'b000, 1'b0, 1'b0);
        repeat (3) tick();

        // load-use: one bubble, then the ADD
        set_d(T_LD, 3'b010, 1'b0, 1'b0);
        exp_at(0, S_IMMD, 0, "lw_imm");
        exp_at(1, S_RWE, 1, "lw_rwe");
        exp_at(3, S_RSW, 1, "lw_rsw");
        exp_at(3, S_RWW, 1, "lw_rww");
        tick();
        set_d(T_R, 3'b000, 1'b0, 1'b0);
        hz(1'b1, 1'b0);
        exp_at(1, S_RWE, 0, "lu_bub_rwe");
        exp_at(1, S_MWE, 0, "lu_bub_mwe");
        tick();
        hz(1'b0, 1'b0);
        exp_at(1, S_RWE, 1, "lu_add_rwe");
        exp_at(1, S_ALUE, 0, "lu_add_alu");
        exp_at(1, S_RWM, 0, "lu_bub_rwm");
        tick();
        set_d(T_NOP, 3'b000, 1'b0, 1'b0);
        repeat (3) tick();

        // taken BEQ flushes the SW behind it
        set_d(T_BR, 3'b000, 1'b0, 1'b0);
        exp_at(0, S_IMMD, 2, "beq_imm");
        exp_at(1, S_BRE, 1, "beq_bre");
        exp_at(1, S_ALUE, 1, "beq_alu");
        tick();
        set_d(T_ST, 3'b010, 1'b0, 1'b0);
        hz(1'b0, 1'b1);
        exp_at(0, S_IMMD, 1, "sw_imm");
        exp_at(1, S_MWE, 0, "flush_mwe");
        exp_at(1, S_BRE, 0, "flush_bre");
        exp_at(1, S_MWM, 0, "beq_mwm");
        exp_at(2, S_MWM, 0, "flush_mwm");
        tick();
        hz(1'b0, 1'b0);
        exp_at(1, S_MWE, 1, "sw_mwe");
        exp_at(2, S_MWM, 1, "sw_mwm");
        exp_at(3, S_RWW, 0, "sw_rww");
        tick();
        set_d(T_NOP, 3'b000, 1'b0, 1'b0);
        repeat (4) tick();

        // DIV occupies E 8 cycles; XOR waits in D
        set_d(T_R, 3'b100, 1'b0, 1'b1);
        tick();
        set_d(T_R, 3'b100, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            exp_at(k, S_STALL, int'(k < 7), "div_stall");
            exp_at(k, S_START, int'(k == 0), "div_start");
            exp_at(k, S_ALUE, 20, "div_alu");
            if (k > 0) exp_at(k, S_RWM, 0, "div_rwm_bub");
        end
        exp_at(8, S_RWM, 1, "div_rwm");
        exp_at(8, S_ALUE, 4, "xor_alu");
        exp_at(8, S_START, 0, "xor_start");
        exp_at(8, S_STALL, 0, "xor_stall");
        for (int k = 0; k < 8; k++) begin
            hz(k == 2, k == 4);
            tick();
        end
        hz(1'b0, 1'b0);
        set_d(T_NOP, 3'b000, 1'b0, 1'b0);
        repeat (4) tick();

        // MUL (1 cycle) then DIVU back to back
        set_d(T_R, 3'b000, 1'b0, 1'b1);
        tick();
        set_d(T_R, 3'b101, 1'b0, 1'b1);
        exp_at(0, S_START, 1, "mul_start");
        exp_at(0, S_STALL, 0, "mul_stall");
        exp_at(0, S_ALUE, 16, "mul_alu");
        tick();
        set_d(T_NOP, 3'b000, 1'b0, 1'b0);
        exp_at(0, S_RWM, 1, "mul_rwm");
        for (int k = 0; k < 8; k++) begin
            exp_at(k, S_STALL, int'(k < 7), "divu_stall");
            exp_at(k, S_START, int'(k == 0), "divu_start");
            exp_at(k, S_ALUE, 21, "divu_alu");
        end
        exp_at(8, S_RWM, 1, "divu_rwm");
        exp_at(8, S_RWE, 0, "divu_after");
        repeat (8) tick();
        repeat (3) tick();

        // reset in the 3rd BUSY cycle of a DIV
        set_d(T_R, 3'b100, 1'b0, 1'b1);
        tick();
        set_d(T_NOP, 3'b000, 1'b0, 1'b0);
        exp_at(0, S_STALL, 1, "div2_stall");
        repeat (3) tick();
        rst = 1'b1;
        exp_at(0, S_STALL, 1, "busy3_stall");
        tick();
        rst = 1'b0;
        exp_at(0, S_STALL, 0, "mrst_stall");
        exp_at(0, S_START, 0, "mrst_start");
        exp_at(0, S_RWE, 0, "mrst_rwe");
        exp_at(0, S_ALUE, 0, "mrst_alu");
        exp_at(0, S_RWM, 0, "mrst_rwm");
        exp_at(0, S_MWM, 0, "mrst_mwm");
        exp_at(0, S_RWW, 0, "mrst_rww");
        set_d(T_R, 3'b000, 1'b0, 1'b0);
        exp_at(1, S_RWE, 1, "post_rwe");
        exp_at(1, S_STALL, 0, "post_stall");
        exp_at(2, S_RWM, 1, "post_rwm");
        exp_at(3, S_RWW, 1, "post_rww");
        tick();
        set_d(T_NOP, 3'b000, 1'b0, 1'b0);
        repeat (10) tick();

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
